// File: rtl/pulpemu_rst_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and sticky cause-bit positions.
package pulpemu_rst_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } rst_state_e;

   localparam int unsigned CAUSE_POR  = 0;
   localparam int unsigned CAUSE_SW   = 1;
   localparam int unsigned CAUSE_SRC0 = 2;

endpackage

// File: rtl/pulpemu_rst_debounce.sv
// One reset source: 2-flop synchroniser then a saturating run-length counter; qual_o is registered.
// Raw high at edge 0 gives qual_o high after edge 2+DEBOUNCE_CYC; no backpressure.
module pulpemu_rst_debounce #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic src_i,
   input  logic en_i,
   output logic qual_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             qual_q, qual_d;

   // The counter keeps running while disabled so enabling a held source qualifies at once.
   always_comb begin
      sync1_d = src_i;
      sync2_d = sync1_q;
      cnt_d   = '0;
      if (sync2_q) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end
      qual_d  = en_i && (cnt_q == CNT_MAX);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         qual_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         qual_q  <= qual_d;
      end
   end

   assign qual_o = qual_q;

endmodule

// File: rtl/pulpemu_reset_seq.sv
// Reset sequencer: any request holds all domains for STRETCH_CYC, then releases them STEP_CYC apart.
// SW request reaches dom_rst_no in 1 cycle, raw sources in DEBOUNCE_CYC+3; no backpressure.
module pulpemu_reset_seq
   import pulpemu_rst_pkg::*;
#(
   parameter int N_SRC        = 2,
   parameter int N_DOM        = 3,
   parameter int DEBOUNCE_CYC = 16,
   parameter int STRETCH_CYC  = 64,
   parameter int STEP_CYC     = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_SRC-1:0]   src_rst_i,
   input  logic [N_SRC-1:0]   src_en_i,
   input  logic               sw_rst_req_i,
   input  logic               cause_clr_i,
   output logic [N_DOM-1:0]   dom_rst_no,
   output logic               busy_o,
   output logic [N_SRC+1:0]   rst_cause_o
);

   if (N_SRC < 1) begin : g_bad_n_src
      $fatal(1, "pulpemu_reset_seq: N_SRC must be >= 1");
   end
   if (N_DOM < 1 || N_DOM > 8) begin : g_bad_n_dom
      $fatal(1, "pulpemu_reset_seq: N_DOM must be in 1..8");
   end
   if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
      $fatal(1, "pulpemu_reset_seq: DEBOUNCE_CYC must be >= 1");
   end
   if (STRETCH_CYC < 1) begin : g_bad_stretch
      $fatal(1, "pulpemu_reset_seq: STRETCH_CYC must be >= 1");
   end
   if (STEP_CYC < 1) begin : g_bad_step
      $fatal(1, "pulpemu_reset_seq: STEP_CYC must be >= 1");
   end

   localparam int STR_W  = $clog2(STRETCH_CYC + 1);
   localparam int STEP_W = $clog2(STEP_CYC + 1);
   localparam logic [STR_W-1:0]  STRETCH_INIT = STR_W'(STRETCH_CYC);
   localparam logic [STEP_W-1:0] STEP_RELOAD  = STEP_W'(STEP_CYC - 1);
   localparam logic [N_DOM-1:0]  DOM_FIRST    = N_DOM'(1);

   logic [N_SRC-1:0] src_qual;
   logic             req;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      pulpemu_rst_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .src_i  (src_rst_i[i]),
         .en_i   (src_en_i[i]),
         .qual_o (src_qual[i])
      );
   end

   assign req = (|src_qual) | sw_rst_req_i;

   rst_state_e         state_q, state_d;
   logic [STR_W-1:0]   stretch_q, stretch_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [N_DOM-1:0]   dom_q, dom_d;
   logic               busy_q, busy_d;
   logic [N_SRC+1:0]   cause_q, cause_d;
   logic [N_SRC+1:0]   cause_set;

   always_comb begin
      state_d   = state_q;
      stretch_d = stretch_q;
      step_d    = step_q;
      dom_d     = dom_q;
      if (req) begin
         state_d   = ST_HOLD;
         stretch_d = STRETCH_INIT;
         dom_d     = '0;
      end else begin
         unique case (state_q)
            ST_HOLD: begin
               dom_d = '0;
               if (stretch_q == '0) begin
                  state_d = ST_RELEASE;
                  dom_d   = DOM_FIRST;
                  step_d  = STEP_RELOAD;
               end else begin
                  stretch_d = stretch_q - STR_W'(1);
               end
            end
            ST_RELEASE: begin
               // Domains release as a thermometer code, lowest index first.
               if (&dom_q) begin
                  state_d = ST_RUN;
               end else if (step_q == '0) begin
                  dom_d  = (dom_q << 1) | DOM_FIRST;
                  step_d = STEP_RELOAD;
               end else begin
                  step_d = step_q - STEP_W'(1);
               end
            end
            ST_RUN: begin
            end
            default: begin
               state_d   = ST_HOLD;
               stretch_d = STRETCH_INIT;
               dom_d     = '0;
            end
         endcase
      end
      busy_d = (state_d != ST_RUN);

      // A set in the same cycle as a clear survives for that bit.
      cause_set                         = '0;
      cause_set[CAUSE_SW]               = sw_rst_req_i;
      cause_set[CAUSE_SRC0 +: N_SRC]    = src_qual;
      cause_d = cause_set | (cause_clr_i ? '0 : cause_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q            <= ST_HOLD;
         stretch_q          <= STRETCH_INIT;
         step_q             <= '0;
         dom_q              <= '0;
         busy_q             <= 1'b1;
         cause_q            <= '0;
         cause_q[CAUSE_POR] <= 1'b1;
      end else begin
         state_q   <= state_d;
         stretch_q <= stretch_d;
         step_q    <= step_d;
         dom_q     <= dom_d;
         busy_q    <= busy_d;
         cause_q   <= cause_d;
      end
   end

   assign dom_rst_no  = dom_q;
   assign busy_o      = busy_q;
   assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_pulpemu_reset_seq.sv
// Bench for pulpemu_reset_seq: timing model derived from the last request edge, directed cases, random run.
module tb_pulpemu_reset_seq;

   localparam int N_SRC = 2;
   localparam int N_DOM = 3;
   localparam int DEB   = 16;
   localparam int STR   = 64;
   localparam int STEP  = 8;

   logic               clk_i        = 1'b0;
   logic               rst_ni       = 1'b1;
   logic [N_SRC-1:0]   src_rst_i    = '0;
   logic [N_SRC-1:0]   src_en_i     = '1;
   logic               sw_rst_req_i = 1'b0;
   logic               cause_clr_i  = 1'b0;
   logic [N_DOM-1:0]   dom_rst_no;
   logic               busy_o;
   logic [N_SRC+1:0]   rst_cause_o;

   always #5 clk_i = ~clk_i;

   pulpemu_reset_seq #(
      .N_SRC        (N_SRC),
      .N_DOM        (N_DOM),
      .DEBOUNCE_CYC (DEB),
      .STRETCH_CYC  (STR),
      .STEP_CYC     (STEP)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .src_rst_i    (src_rst_i),
      .src_en_i     (src_en_i),
      .sw_rst_req_i (sw_rst_req_i),
      .cause_clr_i  (cause_clr_i),
      .dom_rst_no   (dom_rst_no),
      .busy_o       (busy_o),
      .rst_cause_o  (rst_cause_o)
   );

   int n_cmp    = 0;
   int n_bad    = 0;
   int edge_n   = 0;
   int last_req = -1;

   int               run_h [N_SRC][4];
   logic [N_SRC-1:0] en_prev;
   logic [N_SRC+1:0] m_cause;
   logic [N_DOM-1:0] m_dom;
   logic             m_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (after edge %0d)", name, act, exp, edge_n - 1);
      end
   endtask

   // Model: a source counts as a request at edge t when the raw input was high for DEB
   // consecutive edges ending at t-4 and its enable was set at edge t-1. Domain k is up
   // once STR+1+k*STEP edges have passed since the most recent request edge.
   always @(posedge clk_i or negedge rst_ni) begin
      logic             req;
      logic [N_SRC+1:0] set;
      int               rel;
      int               nxt;
      if (!rst_ni) begin
         last_req = edge_n - 1;
         for (int i = 0; i < N_SRC; i++)
            for (int j = 0; j < 4; j++) run_h[i][j] = 0;
         en_prev    = '0;
         m_cause    = '0;
         m_cause[0] = 1'b1;
         m_dom      = '0;
         m_busy     = 1'b1;
      end else begin
         set    = '0;
         set[1] = sw_rst_req_i;
         for (int i = 0; i < N_SRC; i++) begin
            if (en_prev[i] && run_h[i][3] >= DEB) set[2+i] = 1'b1;
            nxt = src_rst_i[i] ? ((run_h[i][0] < DEB) ? run_h[i][0] + 1 : DEB) : 0;
            for (int j = 3; j > 0; j--) run_h[i][j] = run_h[i][j-1];
            run_h[i][0] = nxt;
         end
         en_prev = src_en_i;
         req     = |set[N_SRC+1:1];
         if (req) last_req = edge_n;
         m_cause = (cause_clr_i ? '0 : m_cause) | set;
         rel     = last_req + STR + 1;
         for (int k = 0; k < N_DOM; k++) m_dom[k] = (edge_n >= rel + k * STEP);
         m_busy  = !(edge_n >= rel + (N_DOM - 1) * STEP + 1);
         edge_n++;
      end
   end

   always @(negedge clk_i) begin
      check("model_dom", dom_rst_no, m_dom);
      check("model_busy", busy_o, m_busy);
      check("model_cause", rst_cause_o, m_cause);
   end

   // Returns at the first falling edge after posedge number t.
   task automatic wait_after(input int t);
      int guard = 0;
      while (edge_n <= t && guard < 20000) begin
         @(negedge clk_i);
         guard++;
      end
      if (guard >= 20000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_after: timed out before edge %0d, at edge %0d", t, edge_n);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0, g, p, c, c2, q, e, idx;
      int hold_left [N_SRC];

      #1 rst_ni = 1'b0;
      #1;
      check("por_async_dom", dom_rst_no, 32'h0);
      check("por_async_busy", busy_o, 32'h1);
      check("por_async_cause", rst_cause_o, 32'h1);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      e0 = edge_n;

      // Power-on release sequence
      wait_after(e0 + 63); check("por_hold", dom_rst_no, 32'h0);
      wait_after(e0 + 64); check("por_dom0", dom_rst_no, 32'h1);
      wait_after(e0 + 71); check("por_dom0_only", dom_rst_no, 32'h1);
      wait_after(e0 + 72); check("por_dom1", dom_rst_no, 32'h3);
      wait_after(e0 + 80); check("por_dom2", dom_rst_no, 32'h7);
      check("por_busy_still", busy_o, 32'h1);
      wait_after(e0 + 81); check("por_busy_low", busy_o, 32'h0);
      check("por_cause", rst_cause_o, 32'h1);

      // 10-cycle glitch on source 0 must be filtered
      g = edge_n;
      src_rst_i[0] = 1'b1;
      wait_after(g + 9);
      src_rst_i[0] = 1'b0;
      wait_after(g + 30);
      check("glitch_dom", dom_rst_no, 32'h7);
      check("glitch_cause", rst_cause_o, 32'h1);

      // Pad reset held 40 cycles while running
      p = edge_n;
      src_rst_i[0] = 1'b1;
      wait_after(p + 18); check("pad_before", dom_rst_no, 32'h7);
      wait_after(p + 19); check("pad_assert", dom_rst_no, 32'h0);
      check("pad_cause", rst_cause_o, 32'h5);
      wait_after(p + 39);
      src_rst_i[0] = 1'b0;
      wait_after(p + 107); check("pad_hold_end", dom_rst_no, 32'h0);
      wait_after(p + 108); check("pad_release", dom_rst_no, 32'h1);
      wait_after(p + 116); check("pad_dom1", dom_rst_no, 32'h3);

      // SW reset in the middle of the release staircase
      sw_rst_req_i = 1'b1;
      wait_after(p + 117);
      sw_rst_req_i = 1'b0;
      check("sw_assert", dom_rst_no, 32'h0);
      check("sw_cause", rst_cause_o, 32'h7);
      wait_after(p + 181); check("sw_hold_end", dom_rst_no, 32'h0);
      wait_after(p + 182); check("sw_release", dom_rst_no, 32'h1);
      wait_after(p + 199); check("sw_run", busy_o, 32'h0);

      // Clear and SW request in the same cycle: SW bit survives
      c = edge_n;
      cause_clr_i  = 1'b1;
      sw_rst_req_i = 1'b1;
      wait_after(c);
      cause_clr_i  = 1'b0;
      sw_rst_req_i = 1'b0;
      check("clr_sw_cause", rst_cause_o, 32'h2);
      wait_after(c + 82); check("clr_sw_run", busy_o, 32'h0);
      c2 = edge_n;
      cause_clr_i = 1'b1;
      wait_after(c2);
      cause_clr_i = 1'b0;
      check("clr_only", rst_cause_o, 32'h0);

      // Disabled source held high, then enabled
      src_en_i[1]  = 1'b0;
      src_rst_i[1] = 1'b1;
      q = edge_n;
      wait_after(q + 40);
      check("masked_dom", dom_rst_no, 32'h7);
      check("masked_busy", busy_o, 32'h0);
      check("masked_cause", rst_cause_o, 32'h0);
      e = edge_n;
      src_en_i[1] = 1'b1;
      wait_after(e); check("enable_same", dom_rst_no, 32'h7);
      wait_after(e + 1); check("enable_reset", dom_rst_no, 32'h0);
      check("enable_cause", rst_cause_o, 32'h8);
      src_rst_i[1] = 1'b0;

      // Random traffic, checked every cycle by the model
      for (int i = 0; i < N_SRC; i++) hold_left[i] = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk_i);
         for (int i = 0; i < N_SRC; i++) begin
            if (hold_left[i] == 0) begin
               if (src_rst_i[i]) begin
                  src_rst_i[i] = 1'b0;
                  hold_left[i] = $urandom_range(5, 80);
               end else begin
                  src_rst_i[i] = 1'b1;
                  hold_left[i] = $urandom_range(1, 30);
               end
            end else begin
               hold_left[i]--;
            end
         end
         sw_rst_req_i = ($urandom_range(0, 149) == 0);
         cause_clr_i  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 299) == 0) begin
            idx = $urandom_range(0, N_SRC - 1);
            src_en_i[idx] = ~src_en_i[idx];
         end
         if (cyc == 2000) begin
            #2 rst_ni = 1'b0;
            #1;
            check("mid_async_dom", dom_rst_no, 32'h0);
            check("mid_async_busy", busy_o, 32'h1);
            check("mid_async_cause", rst_cause_o, 32'h1);
         end
         if (cyc == 2004) rst_ni = 1'b1;
      end

      @(negedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulpemu_reset_seq.md
PULPEMU_RESET_SEQ -- requirements
Module: pulpemu_reset_seq

Interface
REQ-001 SHALL have parameter N_SRC, default 2: number of external reset request sources.
REQ-002 SHALL have parameter N_DOM, default 3, legal range 1..8: number of sequenced reset domains.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 16, minimum 1: consecutive synced-high cycles that qualify a source.
REQ-004 SHALL have parameter STRETCH_CYC, default 64, minimum 1: minimum all-domains-held cycles.
REQ-005 SHALL have parameter STEP_CYC, default 8, minimum 1: cycles between successive domain releases.
REQ-006 SHALL have port clk_i, input, 1: single clock; all logic in this domain.
REQ-007 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port src_rst_i, input, N_SRC: raw asynchronous reset requests, active-high (pad reset, JTAG TRST, ...).
REQ-009 SHALL have port src_en_i, input, N_SRC: per-source enable mask, quasi-static.
REQ-010 SHALL have port sw_rst_req_i, input, 1: synchronous one-cycle software reset request.
REQ-011 SHALL have port cause_clr_i, input, 1: clears sticky cause register.
REQ-012 SHALL have port dom_rst_no, output, N_DOM: per-domain resets, active-low, registered.
REQ-013 SHALL have port busy_o, output, 1: high while any domain is held.
REQ-014 SHALL have port rst_cause_o, output, N_SRC+2: sticky cause; bit0 POR, bit1 SW, bit 2+i source i.

Function
REQ-015 SHALL pass each src_rst_i bit through a 2-flop synchroniser, then a debounce counter of width $clog2(DEBOUNCE_CYC+1).
REQ-016 SHALL qualify source i when its synced value is high for DEBOUNCE_CYC consecutive cycles and src_en_i[i]=1; any synced-low cycle clears its counter.
REQ-017 SHALL define request = any qualified source OR sw_rst_req_i.
REQ-018 SHALL implement FSM states HOLD, RELEASE, RUN; reset state HOLD with stretch counter loaded to STRETCH_CYC.
REQ-019 HOLD: all dom_rst_no=0; stretch counter decrements each cycle without request, reloads to STRETCH_CYC on request; at zero, go to RELEASE.
REQ-020 RELEASE: dom_rst_no[0] goes high on the first RELEASE cycle; dom_rst_no[k] goes high exactly k*STEP_CYC cycles after dom_rst_no[0]; released domains stay high.
REQ-021 SHALL enter RUN the cycle after dom_rst_no[N_DOM-1] goes high; busy_o = (state != RUN), registered.
REQ-022 A request in RELEASE or RUN SHALL drive all dom_rst_no low on the next edge and enter HOLD with stretch counter reloaded.
REQ-023 Latency: raw source high at edge 0 gives dom_rst_no low at edge 3+DEBOUNCE_CYC; sw_rst_req_i high at edge 0 gives dom_rst_no low at edge 1.
REQ-024 SHALL set the matching cause bit each cycle a request term is active; cause_clr_i clears all bits; simultaneous set and clear: set wins for that bit.
REQ-025 A source deasserted before DEBOUNCE_CYC cycles SHALL cause no reset and no cause bit.
REQ-026 src_en_i=0 SHALL suppress qualification but keep the debounce counter running.

Reset
REQ-027 rst_ni low SHALL immediately (asynchronously) force dom_rst_no=0, busy_o=1, rst_cause_o=1 (POR only), state HOLD, and all counters and synchronisers cleared.
REQ-028 After rst_ni deassertion, dom_rst_no[0] SHALL go high no earlier than STRETCH_CYC cycles later.

Structure
REQ-029 Package pulpemu_rst_pkg SHALL hold the FSM state enum typedef and cause-bit index constants (CAUSE_POR=0, CAUSE_SW=1, CAUSE_SRC0=2).
REQ-030 SHALL instantiate sub-module pulpemu_rst_debounce (synchroniser + debounce counter) once per source.
REQ-031 SHALL check parameter ranges at elaboration and raise a fatal error when out of range.

Verification (defaults)
REQ-032 POR: release rst_ni at edge 0 -> dom_rst_no 000 until edge 64; then 001, 011 at +8, 111 at +16; busy_o low one cycle later; rst_cause_o=0001.
REQ-033 Glitch: src_rst_i[0] high 10 cycles -> no change to dom_rst_no or rst_cause_o.
REQ-034 Pad reset in RUN: src_rst_i[0] held 40 cycles -> dom_rst_no=000 at edge 19; release begins 64 cycles after the source deasserts; rst_cause_o bit2 set.
REQ-035 SW reset mid-RELEASE (dom_rst_no=011) -> 000 next edge, full 64-cycle hold, bit1 set.
REQ-036 cause_clr_i and sw_rst_req_i in the same cycle -> bit1 remains 1, other bits cleared.
REQ-037 src_en_i[1]=0 with src_rst_i[1] held high -> no reset; enabling it later -> reset 1 cycle after the enable.
